// File: rtl/multicycle_arith_ctrl_pkg.sv
// Shared ALU/MIPS definitions: opcode/funct constants, ALU codes, FSM states.
package multicycle_arith_ctrl_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned FN_W     = 6;
  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned SRCB_W   = 2;

  // Shared ALU operation codes; ALU_NONE is the idle/don't-care value.
  localparam logic [ALU_OP_W-1:0] ALU_NONE = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 3'b101;
  localparam logic [ALU_OP_W-1:0] ALU_NOR  = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 3'b111;

  // ALU B-operand selects (2'b11 is unused).
  localparam logic [SRCB_W-1:0] SRCB_RT   = 2'b00;
  localparam logic [SRCB_W-1:0] SRCB_FOUR = 2'b01;
  localparam logic [SRCB_W-1:0] SRCB_IMM  = 2'b10;

  // Opcodes (IR[31:26]).
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;

  // R-type funct codes (IR[5:0]).
  localparam logic [FN_W-1:0] FN_ADD = 6'h20;
  localparam logic [FN_W-1:0] FN_SUB = 6'h22;
  localparam logic [FN_W-1:0] FN_AND = 6'h24;
  localparam logic [FN_W-1:0] FN_OR  = 6'h25;
  localparam logic [FN_W-1:0] FN_XOR = 6'h26;
  localparam logic [FN_W-1:0] FN_NOR = 6'h27;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_EXC    = 3'd5
  } state_e;

  // Decode result latched in DECODE and replayed in EXEC/WB.
  typedef struct packed {
    logic                legal;
    logic [ALU_OP_W-1:0] alu_op;
    logic                rd_src;
    logic [SRCB_W-1:0]   alu_src_b;
  } decode_t;

  localparam decode_t DECODE_NONE = '{
    legal:     1'b0,
    alu_op:    ALU_NONE,
    rd_src:    1'b0,
    alu_src_b: SRCB_RT
  };

endpackage

// File: rtl/arith_decode.sv
// Combinational opcode/funct classifier for the arithmetic/logic subset.
module arith_decode
  import multicycle_arith_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]     opcode,
  input  logic [FN_W-1:0]     funct,
  output logic                legal,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                rd_src,
  output logic [SRCB_W-1:0]   alu_src_b
);

  // Classify: R-type uses rt and writes rd, I-type uses imm16 and writes rt.
  always_comb begin
    legal     = 1'b0;
    alu_op    = ALU_NONE;
    rd_src    = 1'b0;
    alu_src_b = SRCB_RT;
    case (opcode)
      OP_RTYPE: begin
        legal = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_XOR:  alu_op = ALU_XOR;
          default: legal  = 1'b0;
        endcase
      end
      OP_ADDI: begin
        legal     = 1'b1;
        alu_op    = ALU_ADD;
        rd_src    = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      OP_ANDI: begin
        legal     = 1'b1;
        alu_op    = ALU_AND;
        rd_src    = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      OP_ORI: begin
        legal     = 1'b1;
        alu_op    = ALU_OR;
        rd_src    = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      OP_XORI: begin
        legal     = 1'b1;
        alu_op    = ALU_XOR;
        rd_src    = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_arith_ctrl.sv
// Multicycle controller sequencing one shared ALU: IDLE/FETCH/DECODE/EXEC/WB/EXC.
// Outputs are decoded from the state register and latched decode; only the
// FETCH strobes are qualified by mem_ready.
module multicycle_arith_ctrl
  import multicycle_arith_ctrl_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  input  logic                mem_ready,
  input  logic [OP_W-1:0]     opcode,
  input  logic [FN_W-1:0]     funct,
  output logic                ir_write,
  output logic                pc_write,
  output logic                alu_src_a,
  output logic [SRCB_W-1:0]   alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                aluout_write,
  output logic                rd_src,
  output logic                reg_write,
  output logic                except,
  output logic                busy
);

  state_e  state_q, state_d;
  decode_t dec_q, dec_d;
  logic    except_q, except_d;

  logic                dec_legal;
  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                dec_rd_src;
  logic [SRCB_W-1:0]   dec_alu_src_b;

  arith_decode u_arith_decode (
    .opcode    (opcode),
    .funct     (funct),
    .legal     (dec_legal),
    .alu_op    (dec_alu_op),
    .rd_src    (dec_rd_src),
    .alu_src_b (dec_alu_src_b)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched decode and sticky exception flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dec_q    <= DECODE_NONE;
      except_q <= 1'b0;
    end else begin
      dec_q    <= dec_d;
      except_q <= except_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d      = state_q;
    dec_d        = dec_q;
    except_d     = except_q;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_RT;
    alu_op       = ALU_NONE;
    aluout_write = 1'b0;
    rd_src       = 1'b0;
    reg_write    = 1'b0;
    busy         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        busy = 1'b1;
        if (mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_a = 1'b0;
          alu_src_b = SRCB_FOUR;
          alu_op    = ALU_ADD;
          state_d   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        busy  = 1'b1;
        dec_d = '{
          legal:     dec_legal,
          alu_op:    dec_alu_op,
          rd_src:    dec_rd_src,
          alu_src_b: dec_alu_src_b
        };
        if (dec_legal) begin
          state_d = ST_EXEC;
        end else begin
          state_d  = ST_EXC;
          except_d = 1'b1;
        end
      end
      ST_EXEC: begin
        busy = 1'b1;
        // An illegal latched class cannot reach EXEC; trap defensively if it does.
        if (dec_q.legal) begin
          alu_src_a    = 1'b1;
          alu_src_b    = dec_q.alu_src_b;
          alu_op       = dec_q.alu_op;
          aluout_write = 1'b1;
          state_d      = ST_WB;
        end else begin
          state_d  = ST_EXC;
          except_d = 1'b1;
        end
      end
      ST_WB: begin
        busy      = 1'b1;
        reg_write = 1'b1;
        rd_src    = dec_q.rd_src;
        state_d   = run ? ST_FETCH : ST_IDLE;
      end
      ST_EXC: begin
        state_d = ST_EXC;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign except = except_q;

endmodule

// File: tb/tb_multicycle_arith_ctrl.sv
// Self-checking bench for multicycle_arith_ctrl: directed scenarios plus
// randomized instruction streams checked against a table-driven model.
module tb_multicycle_arith_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic       mem_ready = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       ir_write, pc_write, alu_src_a, aluout_write, rd_src, reg_write, except, busy;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_ir = 0;
  int prev_ir = 0;

  // Reference tables: legal encodings and their ALU codes.
  logic [5:0] r_fn [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h26};
  logic [2:0] r_op [6] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
  logic [5:0] i_oc [4] = '{6'h08, 6'h0C, 6'h0D, 6'h0E};
  logic [2:0] i_op [4] = '{3'b010, 3'b100, 3'b101, 3'b111};

  logic [12:0] obs;
  assign obs = {ir_write, pc_write, alu_src_a, alu_src_b, alu_op,
                aluout_write, rd_src, reg_write, except, busy};

  multicycle_arith_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .run          (run),
    .mem_ready    (mem_ready),
    .opcode       (opcode),
    .funct        (funct),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .aluout_write (aluout_write),
    .rd_src       (rd_src),
    .reg_write    (reg_write),
    .except       (except),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Record the cycle numbers of the two most recent ir_write pulses.
  always @(negedge clock) begin
    if (ir_write === 1'b1) begin
      prev_ir = last_ir;
      last_ir = cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [12:0] mk(input logic ir, input logic pc, input logic sa,
                                     input logic [1:0] sb, input logic [2:0] op,
                                     input logic aw, input logic rs, input logic rw,
                                     input logic ex, input logic bz);
    return {ir, pc, sa, sb, op, aw, rs, rw, ex, bz};
  endfunction

  function automatic void ref_dec(input logic [5:0] op, input logic [5:0] fn,
                                  output logic ok, output logic [2:0] aop,
                                  output logic rs, output logic [1:0] sb);
    ok = 1'b0; aop = 3'b000; rs = 1'b0; sb = 2'b00;
    if (op == 6'h00) begin
      for (int i = 0; i < 6; i++) begin
        if (fn == r_fn[i]) begin ok = 1'b1; aop = r_op[i]; rs = 1'b0; sb = 2'b00; end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (op == i_oc[i]) begin ok = 1'b1; aop = i_op[i]; rs = 1'b1; sb = 2'b10; end
    end
  endfunction

  task automatic chk(input string tag, input logic [12:0] o, input logic [12:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic chk_int(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Called at edge+4; reset asserted between edges, held a cycle, released with
  // run=0, then run raised. Returns at edge+1 of the first FETCH cycle.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    chk("reset_async", obs, 13'd0);
    run = 1'b1;
    mem_ready = 1'b1;
    step();
    #3;
    chk("reset_held", obs, 13'd0);
    #2;
    reset = 1'b1;
    run = 1'b0;
    step();
    #3;
    chk("idle_after_reset", obs, 13'd0);
    run = 1'b1;
    step();
  endtask

  // Stay in IDLE n cycles with run=0, then raise run. Enter at edge+1 in IDLE.
  task automatic idle_then_go(input int n);
    for (int j = 0; j < n; j++) begin
      run = 1'b0;
      mem_ready = 1'($urandom);
      #3;
      chk("idle", obs, 13'd0);
      step();
    end
    run = 1'b1;
    #3;
    chk("idle_exit", obs, 13'd0);
    step();
  endtask

  // Hold in EXC n cycles with noisy inputs. Enter/leave at edge+4.
  task automatic exc_hold(input int n);
    for (int j = 0; j < n; j++) begin
      step();
      run = 1'($urandom);
      mem_ready = 1'($urandom);
      opcode = 6'($urandom);
      funct = 6'($urandom);
      #3;
      chk("exc_hold", obs, mk(0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 1, 0));
    end
  endtask

  // One instruction from FETCH entry (edge+1). mode: 0 run stays high,
  // 1 run drops in EXEC, 2 run drops in WB, 3 reset pulled during WB.
  // Returns ok=0 at edge+4 of the EXC entry cycle for illegal instructions.
  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int waits,
                          input int mode, input bit chained, output logic ok);
    logic [2:0] aop;
    logic       rs;
    logic [1:0] sb;
    ref_dec(op, fn, ok, aop, rs, sb);
    opcode = op;
    funct = fn;
    for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0;
      run = 1'($urandom);
      #3;
      chk("fetch_wait", obs, mk(0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 1));
      step();
    end
    mem_ready = 1'b1;
    #3;
    chk("fetch", obs, mk(1, 1, 0, 2'b01, 3'b010, 0, 0, 0, 0, 1));
    step();
    mem_ready = 1'($urandom);
    run = 1'($urandom);
    #3;
    chk("decode", obs, mk(0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 1));
    if (chained) chk_int("latency", last_ir - prev_ir, 4 + waits);
    step();
    if (!ok) begin
      #3;
      chk("exc_entry", obs, mk(0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 1, 0));
      return;
    end
    opcode = 6'($urandom);
    funct = 6'($urandom);
    mem_ready = 1'($urandom);
    run = (mode == 1) ? 1'b0 : 1'($urandom);
    #3;
    chk("exec", obs, mk(0, 0, 1, sb, aop, 1, 0, 0, 0, 1));
    step();
    run = (mode == 0 || mode == 3) ? 1'b1 : 1'b0;
    mem_ready = 1'($urandom);
    #3;
    chk("wb", obs, mk(0, 0, 0, 2'b00, 3'b000, 0, rs, 1, 0, 1));
    if (mode == 3) begin
      do_reset();
      return;
    end
    step();
  endtask

  initial begin
    logic ok;
    bit   chained;
    int   mode;
    int   pick;
    logic [5:0] op, fn;

    // Reset state with run and mem_ready already high.
    reset = 1'b0;
    run = 1'b1;
    mem_ready = 1'b1;
    step();
    #3;
    chk("reset_state", obs, 13'd0);
    step();
    reset = 1'b1;
    #3;
    chk("idle_after_release", obs, 13'd0);
    step();

    // add, then xori back-to-back (next FETCH 4 cycles after the first).
    do_instr(6'h00, 6'h20, 0, 0, 1'b0, ok);
    do_instr(6'h0E, 6'h15, 0, 0, 1'b1, ok);
    // Three FETCH wait cycles stretch the instruction to 7 cycles.
    do_instr(6'h00, 6'h24, 3, 0, 1'b1, ok);
    // run dropped in EXEC: WB still writes, then IDLE; run raised -> FETCH.
    do_instr(6'h00, 6'h22, 0, 1, 1'b1, ok);
    idle_then_go(2);
    // Reset pulled between edges during WB.
    do_instr(6'h08, 6'h3F, 1, 3, 1'b0, ok);
    chk("except_after_reset", {12'd0, except}, 13'd0);
    // lw traps; except sticky for 20 cycles regardless of run.
    do_instr(6'h23, 6'h00, 0, 0, 1'b0, ok);
    exc_hold(20);
    do_reset();
    // R-type with unknown funct 0x21 traps too.
    do_instr(6'h00, 6'h21, 2, 0, 1'b0, ok);
    exc_hold(5);
    do_reset();

    // Randomized instruction stream.
    chained = 1'b0;
    for (int k = 0; k < 40; k++) begin
      pick = $urandom_range(0, 11);
      if (pick < 6) begin
        op = 6'h00;
        fn = r_fn[pick];
      end else if (pick < 10) begin
        op = i_oc[pick - 6];
        fn = 6'($urandom);
      end else begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end
      mode = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      do_instr(op, fn, $urandom_range(0, 3), mode, chained, ok);
      if (!ok) begin
        exc_hold($urandom_range(1, 4));
        do_reset();
        chained = 1'b0;
      end else if (mode == 1 || mode == 2) begin
        idle_then_go($urandom_range(0, 2));
        chained = 1'b0;
      end else begin
        chained = (mode == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
